exc_irq_ctrl: RTL

Parametrised exception/interrupt controller for the pipelined MIPS core, the sequential successor to the combinational IRQ/exception steering in the control decoder. It synchronises and latches NUM_IRQ external interrupt lines and applies per-line masking and fixed priority. It arbitrates these against decoder exceptions and issues a one-cycle redirect/flush to the fetch and ID stages. It also owns the supervise (kernel) bit, EPC/CAUSE capture and the ERET return path.

---
 rtl/exc_irq_ctrl_if.sv | 47 ++++
 rtl/exc_irq_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/exc_irq_ctrl_if.sv
// ID-stage trap/redirect handshake and CSR access bus between the pipeline and exc_irq_ctrl.
// The pipeline side is the master; the controller is the slave.
interface exc_irq_ctrl_if #(
    parameter int unsigned PC_WIDTH = 32
) ();

    logic                id_valid;
    logic [PC_WIDTH-1:0] id_pc;
    logic                exc_valid;
    logic                eret;
    logic                csr_we;
    logic [1:0]          csr_addr;
    logic [31:0]         csr_wdata;
    logic [31:0]         csr_rdata;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                flush;

    modport master (
        output id_valid,
        output id_pc,
        output exc_valid,
        output eret,
        output csr_we,
        output csr_addr,
        output csr_wdata,
        input  csr_rdata,
        input  redirect,
        input  redirect_pc,
        input  flush
    );

    modport slave (
        input  id_valid,
        input  id_pc,
        input  exc_valid,
        input  eret,
        input  csr_we,
        input  csr_addr,
        input  csr_wdata,
        output csr_rdata,
        output redirect,
        output redirect_pc,
        output flush
    );

endinterface

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt controller: IRQ sync, edge-detect and masking, trap arbitration against
// decoder exceptions, kernel-mode FSM with EPC/CAUSE capture and the ERET return path.
module exc_irq_ctrl #(
    parameter int unsigned         NUM_IRQ    = 4,
    parameter int unsigned         PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] IRQ_VECTOR = PC_WIDTH'(32'h8000_0004),
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR = PC_WIDTH'(32'h8000_0008)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_in,
    exc_irq_ctrl_if.slave       bus,
    output logic                supervise,
    output logic [PC_WIDTH-1:0] epc
);

    typedef enum logic [1:0] {StUser, StKernel, StGuard} state_e;

    state_e state_q, state_d;

    logic [NUM_IRQ-1:0]  irq_meta_q, irq_sync_q, irq_prev_q;
    logic [NUM_IRQ-1:0]  pending_q, pending_d;
    logic [NUM_IRQ-1:0]  mask_q, mask_d;
    logic [PC_WIDTH-1:0] epc_q, epc_d;
    logic [31:0]         cause_q, cause_d;

    logic [NUM_IRQ-1:0]  irq_rise;
    logic [NUM_IRQ-1:0]  irq_enabled;
    logic [NUM_IRQ-1:0]  irq_onehot;
    logic [NUM_IRQ-1:0]  irq_take;
    logic [NUM_IRQ-1:0]  sw_clr;
    logic [7:0]          irq_idx;
    logic                irq_any;

    logic                trap;
    logic [31:0]         trap_cause;
    logic                double_fault;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                csr_wr;

    assign irq_rise    = irq_sync_q & ~irq_prev_q;
    assign irq_enabled = pending_q & mask_q;

    // Descending scan so the lowest enabled index is the one left standing.
    always_comb begin
        irq_any    = 1'b0;
        irq_idx    = '0;
        irq_onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_enabled[i]) begin
                irq_any       = 1'b1;
                irq_idx       = 8'(i);
                irq_onehot    = '0;
                irq_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        trap         = 1'b0;
        trap_cause   = '0;
        irq_take     = '0;
        double_fault = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = EXC_VECTOR;
        case (state_q)
            StUser: begin
                if (bus.id_valid) begin
                    if (bus.exc_valid) begin
                        trap       = 1'b1;
                        trap_cause = 32'h0000_000A;
                    end else if (bus.eret) begin
                        trap       = 1'b1;
                        trap_cause = 32'h0000_000B;
                    end else if (irq_any) begin
                        trap        = 1'b1;
                        trap_cause  = {1'b1, 23'b0, irq_idx};
                        irq_take    = irq_onehot;
                        redirect_pc = IRQ_VECTOR;
                    end
                end
                if (trap) begin
                    redirect = 1'b1;
                    state_d  = StKernel;
                end
            end
            StKernel: begin
                double_fault = bus.exc_valid;
                if (bus.eret && bus.id_valid) begin
                    redirect    = 1'b1;
                    redirect_pc = epc_q;
                    state_d     = StGuard;
                end
            end
            StGuard: begin
                // Let exactly one user instruction through before traps re-arm.
                if (bus.id_valid) begin
                    state_d = StUser;
                end
            end
            default: state_d = StUser;
        endcase
    end

    assign csr_wr = bus.csr_we & supervise;
    assign sw_clr = (csr_wr && bus.csr_addr == 2'd1) ? bus.csr_wdata[NUM_IRQ-1:0] : '0;

    always_comb begin
        mask_d    = mask_q;
        pending_d = (pending_q & ~(sw_clr | irq_take)) | irq_rise;
        epc_d     = epc_q;
        cause_d   = cause_q;
        if (csr_wr && bus.csr_addr == 2'd0) begin
            mask_d = bus.csr_wdata[NUM_IRQ-1:0];
        end
        if (trap) begin
            epc_d   = bus.id_pc;
            cause_d = trap_cause;
        end else begin
            if (csr_wr && bus.csr_addr == 2'd2) begin
                epc_d = PC_WIDTH'(bus.csr_wdata);
            end
            if (csr_wr && bus.csr_addr == 2'd3) begin
                cause_d = bus.csr_wdata;
            end
            if (double_fault) begin
                cause_d[30] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StUser;
            irq_meta_q <= '0;
            irq_sync_q <= '0;
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            epc_q      <= '0;
            cause_q    <= '0;
        end else begin
            state_q    <= state_d;
            irq_meta_q <= irq_in;
            irq_sync_q <= irq_meta_q;
            irq_prev_q <= irq_sync_q;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        bus.csr_rdata = '0;
        case (bus.csr_addr)
            2'd0:    bus.csr_rdata = 32'(mask_q);
            2'd1:    bus.csr_rdata = 32'(pending_q);
            2'd2:    bus.csr_rdata = 32'(epc_q);
            default: bus.csr_rdata = cause_q;
        endcase
    end

    // Gated by reset so a trap in flight vanishes the moment reset asserts.
    assign bus.redirect    = redirect & reset;
    assign bus.flush       = redirect & reset;
    assign bus.redirect_pc = redirect_pc;

    assign supervise = (state_q == StKernel);
    assign epc       = epc_q;

endmodule
